// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline controller: FSM states and per-latch control pair.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_ADVANCE = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STAGE_FREEZE  = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STAGE_BUBBLE  = '{en: 1'b1, flush: 1'b1};
  localparam stage_ctrl_t STAGE_RESET   = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clear has priority.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign q_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Turns hazard/cache/halt status into per-latch enable and flush for the 5-stage pipe,
// and tracks the halt drain sequence plus stall/redirect statistics.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ihit_i,
  input  logic             dhit_i,
  input  logic             dmemREN_i,
  input  logic             dmemWEN_i,
  input  logic             hazard_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic             mem_halt_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redir_cnt_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  pipe_state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;

  logic memWait;
  logic pcEn;
  stage_ctrl_t ifId, idEx, exMem, memWb;
  logic stallInc, redirInc;

  assign memWait = (dmemREN_i | dmemWEN_i) & ~dhit_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Priority mux: a stalled memory access freezes everything upstream before any
  // hazard or redirect is considered, since the ID operands may still change.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    pcEn     = 1'b1;
    ifId     = STAGE_ADVANCE;
    idEx     = STAGE_ADVANCE;
    exMem    = STAGE_ADVANCE;
    memWb    = STAGE_ADVANCE;
    stallInc = 1'b0;
    redirInc = 1'b0;
    if (rst_i) begin
      pcEn  = 1'b0;
      ifId  = STAGE_RESET;
      idEx  = STAGE_RESET;
      exMem = STAGE_RESET;
      memWb = STAGE_RESET;
    end else begin
      case (state_q)
        RUN: begin
          if (memWait) begin
            pcEn  = 1'b0;
            ifId  = STAGE_FREEZE;
            idEx  = STAGE_FREEZE;
            exMem = STAGE_FREEZE;
            memWb = STAGE_BUBBLE;
          end else if (mem_halt_i) begin
            pcEn    = 1'b0;
            ifId    = STAGE_BUBBLE;
            idEx    = STAGE_BUBBLE;
            exMem   = STAGE_BUBBLE;
            state_d = DRAIN;
            drain_d = DW'(DRAIN_CYCLES - 1);
          end else if (hazard_i) begin
            pcEn = 1'b0;
            ifId = STAGE_FREEZE;
            idEx = STAGE_BUBBLE;
          end else if ((branch_i | jump_i) && ihit_i) begin
            ifId     = STAGE_BUBBLE;
            redirInc = 1'b1;
          end else if (branch_i | jump_i) begin
            pcEn = 1'b0;
            ifId = STAGE_FREEZE;
            idEx = STAGE_BUBBLE;
          end else if (!ihit_i) begin
            pcEn = 1'b0;
            ifId = STAGE_BUBBLE;
          end
          stallInc = ~pcEn;
        end
        DRAIN: begin
          pcEn  = 1'b0;
          ifId  = STAGE_BUBBLE;
          idEx  = STAGE_BUBBLE;
          exMem = STAGE_BUBBLE;
          if (drain_q == '0) begin
            state_d = HALTED;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
        HALTED: begin
          pcEn  = 1'b0;
          ifId  = STAGE_FREEZE;
          idEx  = STAGE_FREEZE;
          exMem = STAGE_FREEZE;
          memWb = STAGE_FREEZE;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pc_en_o        = pcEn;
  assign if_id_en_o     = ifId.en;
  assign id_ex_en_o     = idEx.en;
  assign ex_mem_en_o    = exMem.en;
  assign mem_wb_en_o    = memWb.en;
  assign if_id_flush_o  = ifId.flush;
  assign id_ex_flush_o  = idEx.flush;
  assign ex_mem_flush_o = exMem.flush;
  assign mem_wb_flush_o = memWb.flush;
  assign halted_o       = (state_q == HALTED) && !rst_i;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .clear_i (rst_i),
    .inc_i   (stallInc),
    .q_o     (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk_i   (clk_i),
    .clear_i (rst_i),
    .inc_i   (redirInc),
    .q_o     (redir_cnt_o)
  );

endmodule
